// File: rtl/io_map_pkg.sv
// Shared port map and constants for the CPU port I/O responder.
// Holds the port addresses, the interrupt bit positions and the data width.
package io_map_pkg;

   localparam int unsigned DataW = 8;

   // Read ports
   localparam logic [DataW-1:0] PortSwitches  = 8'h20;
   localparam logic [DataW-1:0] PortButtons   = 8'h21;
   localparam logic [DataW-1:0] PortIrqStatus = 8'h22;
   localparam logic [DataW-1:0] PortFifoHead  = 8'h23;
   localparam logic [DataW-1:0] PortFifoCount = 8'h25;
   // Write ports (LEDS, SSEG and IRQ_MASK read back as well)
   localparam logic [DataW-1:0] PortFifoPop   = 8'h24;
   localparam logic [DataW-1:0] PortLeds      = 8'h40;
   localparam logic [DataW-1:0] PortSseg      = 8'h41;
   localparam logic [DataW-1:0] PortIrqMask   = 8'h42;
   localparam logic [DataW-1:0] PortIrqAck    = 8'h43;

   // Interrupt layout: one pending bit per button, then the FIFO bit
   localparam int unsigned NumButtons = 4;
   localparam int unsigned IrqFifoBit = 4;
   localparam int unsigned NumIrq     = 5;
   // IRQ_ACK data bit that clears the sticky FIFO overflow flag
   localparam int unsigned AckOvfBit  = 7;

endpackage

// File: rtl/debounce.sv
// Debouncer for one already-synchronized level.
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset
//   sig_i    synchronized raw level
//   level_o  accepted (debounced) level
//   rise_o   one-cycle pulse, high in the cycle the level is accepted 0->1
module debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic sig_i,
   output logic level_o,
   output logic rise_o
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic            level_q, level_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Count consecutive samples that disagree with the accepted level;
   // any agreeing sample restarts the count.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      rise_o  = 1'b0;
      if (sig_i != level_q) begin
         if (cnt_q == CntLast) begin
            level_d = sig_i;
            rise_o  = sig_i;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/port_io_responder.sv
// CPU-facing port I/O responder: switch/button inputs, LED and seven-segment
// registers, a masked interrupt controller and a receive FIFO.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   port_id, out_port   CPU port address and write data
//   io_strb             one-cycle CPU write strobe
//   in_port             combinational read data for port_id
//   interrupt           registered interrupt request
//   switches, buttons   asynchronous raw inputs
//   fifo_wr, fifo_din   external producer push interface
//   fifo_full           FIFO holds FIFO_DEPTH entries
//   leds, sseg          output registers
module port_io_responder
   import io_map_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned FIFO_DEPTH      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       io_strb,
   output logic [7:0] in_port,
   output logic       interrupt,
   input  logic [7:0] switches,
   input  logic [3:0] buttons,
   input  logic       fifo_wr,
   input  logic [7:0] fifo_din,
   output logic       fifo_full,
   output logic [7:0] leds,
   output logic [7:0] sseg
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

   logic [7:0]            sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
   logic [NumButtons-1:0] btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
   logic [NumButtons-1:0] btn_level, btn_rise;
   logic [7:0]            leds_q, leds_d, sseg_q, sseg_d, mask_q, mask_d;
   logic [NumIrq-1:0]     pend_q, pend_d, pend_set;
   logic                  irq_q, irq_d, ovf_q, ovf_d;
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [7:0]            mem_q [FIFO_DEPTH];
   logic [7:0]            mem_d [FIFO_DEPTH];
   logic                  wr_leds, wr_sseg, wr_mask, wr_ack, wr_pop;
   logic                  pop_ok, push_ok, fifo_event;
   logic [7:0]            fifo_head;

   for (genvar i = 0; i < NumButtons; i++) begin : g_debounce
      debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .reset  (reset),
         .sig_i  (btn_s2_q[i]),
         .level_o(btn_level[i]),
         .rise_o (btn_rise[i])
      );
   end

   always_comb begin
      sw_s1_d  = switches;
      sw_s2_d  = sw_s1_q;
      btn_s1_d = buttons;
      btn_s2_d = btn_s1_q;
   end

   // Write decode
   always_comb begin
      wr_leds = io_strb && (port_id == PortLeds);
      wr_sseg = io_strb && (port_id == PortSseg);
      wr_mask = io_strb && (port_id == PortIrqMask);
      wr_ack  = io_strb && (port_id == PortIrqAck);
      wr_pop  = io_strb && (port_id == PortFifoPop);
   end

   // FIFO: a pop frees the slot a same-cycle push into a full FIFO needs
   always_comb begin
      pop_ok     = wr_pop && (cnt_q != '0);
      push_ok    = fifo_wr && ((cnt_q != FullCnt) || pop_ok);
      fifo_event = push_ok && (cnt_q == '0);
      wr_ptr_d   = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d   = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
      mem_d = mem_q;
      if (push_ok) mem_d[wr_ptr_q] = fifo_din;
      fifo_head = (cnt_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
   end

   // Registers and interrupt state; set events win over acknowledge clears
   always_comb begin
      leds_d = wr_leds ? out_port : leds_q;
      sseg_d = wr_sseg ? out_port : sseg_q;
      mask_d = wr_mask ? out_port : mask_q;

      pend_set                       = '0;
      pend_set[NumButtons-1:0]       = btn_rise;
      pend_set[IrqFifoBit]           = fifo_event;
      pend_d = (wr_ack ? (pend_q & ~out_port[NumIrq-1:0]) : pend_q) | pend_set;

      ovf_d = (wr_ack && out_port[AckOvfBit]) ? 1'b0 : ovf_q;
      if (fifo_wr && !push_ok) ovf_d = 1'b1;

      irq_d = |(pend_q & mask_q[NumIrq-1:0]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         leds_q   <= '0;
         sseg_q   <= '0;
         mask_q   <= '0;
         pend_q   <= '0;
         irq_q    <= 1'b0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         sw_s1_q  <= sw_s1_d;
         sw_s2_q  <= sw_s2_d;
         btn_s1_q <= btn_s1_d;
         btn_s2_q <= btn_s2_d;
         leds_q   <= leds_d;
         sseg_q   <= sseg_d;
         mask_q   <= mask_d;
         pend_q   <= pend_d;
         irq_q    <= irq_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: the head is gated by the count
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      in_port = '0;
      case (port_id)
         PortSwitches:  in_port = sw_s2_q;
         PortButtons:   in_port = DataW'(btn_level);
         PortIrqStatus: in_port = DataW'(pend_q);
         PortFifoHead:  in_port = fifo_head;
         PortFifoCount: in_port = {ovf_q, 7'(cnt_q)};
         PortLeds:      in_port = leds_q;
         PortSseg:      in_port = sseg_q;
         PortIrqMask:   in_port = mask_q;
         default:       in_port = '0;
      endcase
   end

   assign interrupt = irq_q;
   assign fifo_full = (cnt_q == FullCnt);
   assign leds      = leds_q;
   assign sseg      = sseg_q;

endmodule

// File: tb/tb_port_io_responder.sv
module tb_port_io_responder;

   localparam int Deb   = 16;
   localparam int Depth = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] port_id, out_port, in_port, switches, fifo_din, leds, sseg;
   logic       io_strb, interrupt, fifo_wr, fifo_full;
   logic [3:0] buttons;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   port_io_responder #(
      .DEBOUNCE_CYCLES(Deb),
      .FIFO_DEPTH     (Depth)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .port_id  (port_id),
      .out_port (out_port),
      .io_strb  (io_strb),
      .in_port  (in_port),
      .interrupt(interrupt),
      .switches (switches),
      .buttons  (buttons),
      .fifo_wr  (fifo_wr),
      .fifo_din (fifo_din),
      .fifo_full(fifo_full),
      .leds     (leds),
      .sseg     (sseg)
   );

   // ---------------- reference model ----------------
   logic [7:0] m_leds, m_sseg, m_mask;
   logic [4:0] m_pend;
   logic       m_irq, m_ovf;
   logic [7:0] m_q[$];
   logic [7:0] m_sw1, m_sw2;
   logic [3:0] m_b1, m_b2, m_lvl, m_runv;
   int         m_run[4];

   function automatic logic [7:0] mread(input logic [7:0] p);
      case (p)
         8'h20:   return m_sw2;
         8'h21:   return {4'b0, m_lvl};
         8'h22:   return {3'b0, m_pend};
         8'h23:   return (m_q.size() > 0) ? m_q[0] : 8'h00;
         8'h25:   return {m_ovf, 7'(m_q.size())};
         8'h40:   return m_leds;
         8'h41:   return m_sseg;
         8'h42:   return m_mask;
         default: return 8'h00;
      endcase
   endfunction

   // Advance the model by one rising edge using the inputs now applied
   task automatic model_edge();
      logic [3:0] rise;
      logic [4:0] pend;
      logic       pop, ack, pop_ok, push_ok, fifo_ev;
      int         old_n;
      if (reset) begin
         m_leds = 0; m_sseg = 0; m_mask = 0; m_pend = 0; m_irq = 0; m_ovf = 0;
         m_q.delete();
         m_sw1 = 0; m_sw2 = 0; m_b1 = 0; m_b2 = 0; m_lvl = 0; m_runv = 0;
         for (int i = 0; i < 4; i++) m_run[i] = 0;
         return;
      end
      // A level is accepted once the last Deb synchronized samples all show it
      rise = 4'b0;
      for (int i = 0; i < 4; i++) begin
         if (m_b2[i] == m_runv[i]) m_run[i]++;
         else begin
            m_runv[i] = m_b2[i];
            m_run[i]  = 1;
         end
         if (m_run[i] >= Deb && m_runv[i] != m_lvl[i]) begin
            m_lvl[i] = m_runv[i];
            rise[i]  = m_runv[i];
         end
      end
      pop     = io_strb && port_id == 8'h24;
      ack     = io_strb && port_id == 8'h43;
      old_n   = m_q.size();
      pop_ok  = pop && old_n > 0;
      push_ok = fifo_wr && (old_n < Depth || pop_ok);
      if (pop_ok) void'(m_q.pop_front());
      if (push_ok) m_q.push_back(fifo_din);
      fifo_ev = (old_n == 0) && (m_q.size() == 1);

      m_irq = |(m_pend & m_mask[4:0]);
      pend  = m_pend;
      if (ack) pend = pend & ~out_port[4:0];
      m_pend = pend | {fifo_ev, rise};
      if (ack && out_port[7]) m_ovf = 1'b0;
      if (fifo_wr && !push_ok) m_ovf = 1'b1;

      if (io_strb && port_id == 8'h40) m_leds = out_port;
      if (io_strb && port_id == 8'h41) m_sseg = out_port;
      if (io_strb && port_id == 8'h42) m_mask = out_port;

      m_sw2 = m_sw1; m_sw1 = switches;
      m_b2  = m_b1;  m_b1  = buttons;
   endtask

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] p, input logic [7:0] d);
      port_id  = p;
      out_port = d;
      io_strb  = 1'b1;
      cycle();
      io_strb  = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] p);
      port_id = p;
      #1;
      check_eq(tag, in_port, mread(p));
   endtask

   task automatic outs_chk(input string tag);
      check_eq({tag, ".irq"}, interrupt, m_irq);
      check_eq({tag, ".full"}, fifo_full, m_q.size() == Depth);
      check_eq({tag, ".leds"}, leds, m_leds);
      check_eq({tag, ".sseg"}, sseg, m_sseg);
   endtask

   task automatic push(input logic [7:0] d);
      fifo_wr  = 1'b1;
      fifo_din = d;
      cycle();
      fifo_wr  = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] exp_seq[8];
   int         hold[4];
   logic [7:0] ports[11];

   initial begin
      reset = 1'b1; port_id = 0; out_port = 0; io_strb = 0; switches = 0;
      buttons = 0; fifo_wr = 0; fifo_din = 0;
      repeat (3) cycle();
      reset = 1'b0;
      outs_chk("reset");
      check_eq("reset.irq_const", interrupt, 1'b0);
      rd_chk("reset.count", 8'h25);
      rd_chk("reset.status", 8'h22);

      // LED write and unmapped read
      wr(8'h40, 8'hA5);
      check_eq("leds_a5", leds, 8'hA5);
      port_id = 8'h40; #1;
      check_eq("rd_leds_a5", in_port, 8'hA5);
      port_id = 8'h7F; #1;
      check_eq("rd_unmapped", in_port, 8'h00);
      wr(8'h41, 8'h3C);
      outs_chk("sseg");

      // Button 2 held: pending, interrupt, acknowledge
      wr(8'h42, 8'h04);
      buttons = 4'b0100;
      repeat (20) cycle();
      port_id = 8'h22; #1;
      check_eq("btn2_status", in_port, 8'h04);
      check_eq("btn2_irq", interrupt, 1'b1);
      outs_chk("btn2");
      wr(8'h43, 8'h04);
      cycle();
      check_eq("btn2_ack_irq", interrupt, 1'b0);
      rd_chk("btn2_ack_status", 8'h22);

      // Bouncing button never accepted
      buttons = 4'b0000;
      repeat (25) cycle();
      for (int i = 0; i < 100; i++) begin
         if (i % 5 == 0) buttons[0] = ~buttons[0];
         cycle();
      end
      port_id = 8'h22; #1;
      check_eq("bounce_status", in_port, 8'h00);
      port_id = 8'h21; #1;
      check_eq("bounce_buttons", in_port, 8'h00);
      buttons = 4'b0000;

      // Fill past full, then drain
      for (int i = 0; i < 9; i++) push(8'h11 + 8'(i));
      check_eq("fill_full", fifo_full, 1'b1);
      port_id = 8'h25; #1;
      check_eq("fill_count", in_port, 8'h88);
      port_id = 8'h23; #1;
      check_eq("fill_head", in_port, 8'h11);
      for (int i = 0; i < 8; i++) begin
         port_id = 8'h23; #1;
         check_eq($sformatf("drain_%0d", i), in_port, 8'h11 + 8'(i));
         wr(8'h24, 8'h00);
      end
      port_id = 8'h23; #1;
      check_eq("drain_empty_head", in_port, 8'h00);
      rd_chk("drain_count_sticky", 8'h25);
      wr(8'h43, 8'h90);
      port_id = 8'h25; #1;
      check_eq("ovf_cleared", in_port, 8'h00);
      outs_chk("drain");

      // Full with simultaneous push and pop
      for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
      fifo_wr = 1'b1; fifo_din = 8'h55;
      wr(8'h24, 8'h00);
      fifo_wr = 1'b0;
      port_id = 8'h25; #1;
      check_eq("pushpop_count", in_port, 8'h08);
      for (int i = 0; i < 8; i++) exp_seq[i] = (i < 7) ? 8'h61 + 8'(i) : 8'h55;
      for (int i = 0; i < 8; i++) begin
         port_id = 8'h23; #1;
         check_eq($sformatf("pushpop_%0d", i), in_port, exp_seq[i]);
         wr(8'h24, 8'h00);
      end
      wr(8'h43, 8'hFF);

      // Reset during pending interrupt with a 3-entry FIFO
      wr(8'h42, 8'h1F);
      for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i));
      cycle();
      check_eq("pre_reset_irq", interrupt, 1'b1);
      reset = 1'b1; io_strb = 1'b1; port_id = 8'h40; out_port = 8'hFF;
      fifo_wr = 1'b1; fifo_din = 8'h99;
      cycle();
      reset = 1'b0; io_strb = 1'b0; fifo_wr = 1'b0;
      check_eq("post_reset_irq", interrupt, 1'b0);
      check_eq("post_reset_leds", leds, 8'h00);
      port_id = 8'h25; #1;
      check_eq("post_reset_count", in_port, 8'h00);

      // Randomized traffic against the model
      ports = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h40, 8'h41, 8'h42, 8'h43, 8'h24};
      for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 40);
      for (int c = 0; c < 3000; c++) begin
         reset    = ($urandom_range(0, 499) == 0);
         io_strb  = ($urandom_range(0, 2) == 0);
         port_id  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : ports[$urandom_range(0, 10)];
         out_port = 8'($urandom);
         fifo_wr  = $urandom_range(0, 1) == 1;
         fifo_din = 8'($urandom);
         switches = 8'($urandom);
         for (int i = 0; i < 4; i++) begin
            hold[i]--;
            if (hold[i] <= 0) begin
               buttons[i] = ~buttons[i];
               hold[i]    = $urandom_range(1, 40);
            end
         end
         cycle();
         io_strb = 1'b0;
         fifo_wr = 1'b0;
         outs_chk("rand");
         rd_chk("rand.rd", ($urandom_range(0, 5) == 0) ? 8'($urandom) : ports[$urandom_range(0, 10)]);
      end
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
